// File: rtl/iobus_ctrl.sv
// Decodes one master IO request onto N_SLOTS peripheral windows and returns data/status on a four-phase ready handshake.
// Hit: strobes after the request edge and ready after the slot_ready edge; miss: ready one cycle after request; ready held until request drops.
module iobus_ctrl #(
  parameter int IO_ADDR_WIDTH = 8,
  parameter int IO_DATA_WIDTH = 32,
  parameter int N_SLOTS       = 4,
  parameter logic [N_SLOTS*IO_ADDR_WIDTH-1:0] SLOT_BASE = {8'hB0, 8'hA0, 8'h90, 8'h80},
  parameter logic [N_SLOTS*IO_ADDR_WIDTH-1:0] SLOT_MASK = {4{8'hF0}},
  parameter int TIMEOUT       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               read,
  input  logic                               write,
  input  logic [IO_ADDR_WIDTH-1:0]           addr,
  input  logic [IO_DATA_WIDTH-1:0]           wdata,
  output logic [IO_DATA_WIDTH-1:0]           rdata,
  output logic                               ready,
  output logic                               err,
  output logic [N_SLOTS-1:0]                 slot_sel,
  output logic                               slot_read,
  output logic                               slot_write,
  output logic [IO_ADDR_WIDTH-1:0]           slot_addr,
  output logic [IO_DATA_WIDTH-1:0]           slot_wdata,
  input  logic [N_SLOTS*IO_DATA_WIDTH-1:0]   slot_rdata,
  input  logic [N_SLOTS-1:0]                 slot_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                     state;
  logic   [CW-1:0]            cnt;
  logic                       hit;
  logic   [N_SLOTS-1:0]       hit_oh;
  logic   [IO_ADDR_WIDTH-1:0] hit_off;
  logic                       sel_ready;
  logic   [IO_DATA_WIDTH-1:0] sel_rdata;

  // Scan from the top so the lowest-index matching window overrides the rest.
  always_comb begin
    hit     = 1'b0;
    hit_oh  = '0;
    hit_off = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if ((addr & SLOT_MASK[i*IO_ADDR_WIDTH +: IO_ADDR_WIDTH]) ==
          SLOT_BASE[i*IO_ADDR_WIDTH +: IO_ADDR_WIDTH]) begin
        hit       = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        hit_off   = addr & ~SLOT_MASK[i*IO_ADDR_WIDTH +: IO_ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    sel_ready = |(slot_sel & slot_ready);
    sel_rdata = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (slot_sel[i]) sel_rdata = sel_rdata | slot_rdata[i*IO_DATA_WIDTH +: IO_DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata      <= '0;
      ready      <= 1'b0;
      err        <= 1'b0;
      slot_sel   <= '0;
      slot_read  <= 1'b0;
      slot_write <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read && write) begin
            state <= DONE;
            ready <= 1'b1;
            err   <= 1'b1;
            rdata <= '0;
          end else if (read || write) begin
            if (hit) begin
              state      <= ACCESS;
              slot_sel   <= hit_oh;
              slot_read  <= read;
              slot_write <= write;
              slot_addr  <= hit_off;
              slot_wdata <= wdata;
              cnt        <= '0;
            end else begin
              state <= DONE;
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (sel_ready || cnt == CW'(TIMEOUT - 1)) begin
            // A ready arriving on the last allowed cycle still counts as success.
            state      <= DONE;
            ready      <= 1'b1;
            err        <= !sel_ready;
            rdata      <= (sel_ready && slot_read) ? sel_rdata : '0;
            slot_sel   <= '0;
            slot_read  <= 1'b0;
            slot_write <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!read && !write) begin
            state <= IDLE;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobus_ctrl.sv
// Directed bench for iobus_ctrl: default decode instance plus an overlapping-window instance sharing the same stimulus.
module tb_iobus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [127:0] slot_rdata;
  logic [3:0]  slot_ready;

  logic [31:0] rdata, o_rdata;
  logic        ready, o_ready, err, o_err;
  logic [3:0]  slot_sel, o_slot_sel;
  logic        slot_read, o_slot_read, slot_write, o_slot_write;
  logic [7:0]  slot_addr, o_slot_addr;
  logic [31:0] slot_wdata, o_slot_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iobus_ctrl dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .slot_sel(slot_sel),
    .slot_read(slot_read), .slot_write(slot_write), .slot_addr(slot_addr),
    .slot_wdata(slot_wdata), .slot_rdata(slot_rdata), .slot_ready(slot_ready)
  );

  iobus_ctrl #(
    .SLOT_BASE({8'hB0, 8'hA0, 8'h80, 8'h80}),
    .SLOT_MASK({8'hF0, 8'hF0, 8'hC0, 8'hF0})
  ) ovl (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .wdata(wdata),
    .rdata(o_rdata), .ready(o_ready), .err(o_err), .slot_sel(o_slot_sel),
    .slot_read(o_slot_read), .slot_write(o_slot_write), .slot_addr(o_slot_addr),
    .slot_wdata(o_slot_wdata), .slot_rdata(slot_rdata), .slot_ready(slot_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic ok;
    rst = 1'b1; read = 0; write = 0; addr = '0; wdata = '0;
    slot_rdata = '0; slot_ready = '0;
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_outs", {rdata[7:0], err, slot_sel, slot_read, slot_write, slot_addr, slot_wdata[7:0]}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: write hit on slot0, ready two cycles after strobe
    write = 1; addr = 8'h83; wdata = 32'h12345678;
    step();
    chk("t1_sel", {28'd0, slot_sel}, 32'h1);
    chk("t1_strobe", {30'd0, slot_write, slot_read}, 32'h2);
    chk("t1_addr", {24'd0, slot_addr}, 32'h03);
    chk("t1_wdata", slot_wdata, 32'h12345678);
    step();
    chk("t1_not_ready", {31'd0, ready}, 32'd0);
    slot_ready = 4'b0001;
    step();
    slot_ready = '0;
    chk("t1_ready_err", {30'd0, ready, err}, 32'h2);
    chk("t1_strobe_drop", {26'd0, slot_sel, slot_write, slot_read}, 32'd0);
    chk("t1_rdata", rdata, 32'd0);
    step(); step();
    chk("t1_held", {31'd0, ready}, 32'd1);
    write = 0;
    step();
    chk("t1_release", {31'd0, ready}, 32'd0);

    // 2: read slot1 with ready on the first ACCESS cycle
    read = 1; addr = 8'h95; slot_rdata[63:32] = 32'hDEADBEEF;
    step();
    chk("t2_sel", {28'd0, slot_sel}, 32'h2);
    chk("t2_addr", {24'd0, slot_addr}, 32'h05);
    chk("t2_read", {30'd0, slot_write, slot_read}, 32'h1);
    slot_ready = 4'b0010;
    step();
    slot_ready = '0;
    chk("t2_ready_err", {30'd0, ready, err}, 32'h2);
    chk("t2_rdata", rdata, 32'hDEADBEEF);
    read = 0;
    step();
    chk("t2_clear", {rdata[30:0], ready}, 32'd0);

    // 3: unmapped read
    read = 1; addr = 8'h40;
    step();
    chk("t3_ready_err", {30'd0, ready, err}, 32'h3);
    chk("t3_rdata", rdata, 32'd0);
    chk("t3_no_strobe", {26'd0, slot_sel, slot_write, slot_read}, 32'd0);
    read = 0;
    step();

    // 4a: timeout, write strobe high for exactly TIMEOUT cycles
    write = 1; addr = 8'hA0;
    step();
    n = 0;
    for (int i = 0; i < 40 && slot_write; i++) begin
      n++;
      step();
    end
    chk("t4_strobe_cycles", n, 32'd16);
    chk("t4_ready_err", {30'd0, ready, err}, 32'h3);
    write = 0;
    step();

    // 4b: ready on the timeout cycle wins
    write = 1; addr = 8'hA0;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("t4b_not_ready", {30'd0, ready, slot_write}, 32'h1);
    slot_ready = 4'b0100;
    step();
    slot_ready = '0;
    chk("t4b_ready_err", {30'd0, ready, err}, 32'h2);
    write = 0;
    step();

    // 5: read and write together, then hold read in DONE
    read = 1; write = 1; addr = 8'h80;
    step();
    chk("t5_ready_err", {30'd0, ready, err}, 32'h3);
    chk("t5_no_strobe", {26'd0, slot_sel, slot_write, slot_read}, 32'd0);
    write = 0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!ready || slot_read || slot_sel != 4'd0) ok = 1'b0;
    end
    chk("t5_no_reexec", {31'd0, ok}, 32'd1);
    read = 0;
    step();
    chk("t5_release", {30'd0, ready, err}, 32'd0);

    // 6: overlap priority, then asynchronous reset mid-ACCESS
    read = 1; addr = 8'h85;
    step();
    chk("t6_ovl_sel", {28'd0, o_slot_sel}, 32'h1);
    chk("t6_ovl_addr", {24'd0, o_slot_addr}, 32'h05);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rst", {23'd0, slot_sel, slot_read, slot_write, ready, err, o_slot_sel[0], o_slot_read},
        32'd0);
    chk("t6_async_rst_data", slot_addr | slot_wdata[7:0] | rdata[7:0], 32'd0);
    read = 0;
    step();
    rst = 1'b0;
    step();
    read = 1; addr = 8'h85; slot_rdata[31:0] = 32'hCAFEF00D;
    step();
    chk("t6_resume_sel", {28'd0, slot_sel}, 32'h1);
    slot_ready = 4'b0001;
    step();
    slot_ready = '0;
    chk("t6_resume_ready", {30'd0, ready, err}, 32'h2);
    chk("t6_resume_rdata", rdata, 32'hCAFEF00D);
    chk("t6_ovl_rdata", o_rdata, 32'hCAFEF00D);
    read = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/iobus_ctrl.md
Name: iobus_ctrl

Overview:
Parametrised IO bus controller: the successor to the single-slot IO bus.
- Decodes one master IO request into one of N_SLOTS peripheral windows and drives that slot's strobes.
- Waits for the slot's ready, then returns data/status to the master over a four-phase ready handshake.
- Adds unmapped-address error, per-access timeout, split read/write data and registered read-back.
- Sits between the address-space splitter and the peripheral blocks (leds, buttons, timers).

Parameters:
IO_ADDR_WIDTH, 8, master/slot address width
IO_DATA_WIDTH, 32, data width
N_SLOTS, 4, number of peripheral windows (1..16)
SLOT_BASE, {8'hB0,8'h A0,8'h90,8'h80}, concatenated base addresses, slot i at bits [i*IO_ADDR_WIDTH +: IO_ADDR_WIDTH]
SLOT_MASK, {4{8'hF0}}, concatenated decode masks; slot i hits when (addr & mask_i) == base_i
TIMEOUT, 16, max cycles in ACCESS before error (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
read  in  1  master read request, level, held until ready
write  in  1  master write request, level, held until ready
addr  in  IO_ADDR_WIDTH  master address
wdata  in  IO_DATA_WIDTH  master write data
rdata  out  IO_DATA_WIDTH  read data, valid while ready=1
ready  out  1  transaction complete, held until request drops
err  out  1  error status, valid while ready=1
slot_sel  out  N_SLOTS  one-hot selected slot
slot_read  out  1  read strobe to selected slot
slot_write  out  1  write strobe to selected slot
slot_addr  out  IO_ADDR_WIDTH  offset: latched addr & ~mask_i
slot_wdata  out  IO_DATA_WIDTH  latched wdata
slot_rdata  in  N_SLOTS*IO_DATA_WIDTH  concatenated slot read data
slot_ready  in  N_SLOTS  per-slot completion

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high.
- Reset: state=IDLE. rdata, ready, err, slot_sel, slot_read, slot_write, slot_addr, slot_wdata and the timeout counter are all 0.
- Reset mid-ACCESS drops strobes immediately (asynchronously). No completion is reported.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE, read^write=1:
  - Latch addr, wdata and op.
  - Decode: the lowest-index matching slot wins when windows overlap.
  - Hit: go to ACCESS, assert slot_sel[i] and slot_read or slot_write, load slot_addr/slot_wdata, clear counter.
  - Miss: go to DONE with err=1, rdata=0, no strobe.
- IDLE, read&write=1: go to DONE with err=1, no slot access.
- IDLE, no request: stay in IDLE.
- ACCESS:
  - Strobes and slot_sel are held stable; counter increments each cycle.
  - slot_ready[i]=1 (selected slot only; others ignored): for reads, register slot_rdata[i] into rdata; for writes, rdata=0. Set err=0, drop strobes and slot_sel, go to DONE.
  - Counter == TIMEOUT-1 without ready: drop strobes, set err=1, rdata=0, go to DONE.
  - Ready and timeout in the same cycle: ready wins (err=0).
- DONE:
  - ready=1; rdata and err are held.
  - Stay until read==0 && write==0, then go to IDLE with ready, err and rdata cleared.
  - A request still high is never re-executed.
- Latency: request sampled at edge 0 → strobes visible after edge 0. slot_ready seen at edge k → ready after edge k. Minimum 2 cycles for a hit, 1 cycle for a miss.
- Counter width: $clog2(TIMEOUT+1). It saturates and never wraps.
- addr, wdata and op are sampled only in IDLE. Changes while in ACCESS/DONE are ignored.

Test Plan:
1. Write 0x12345678 to 0x83; slot0 ready 2 cycles after strobe → slot_sel=0001, slot_write=1, slot_addr=0x03, slot_wdata=0x12345678; then ready=1, err=0, held until write drops.
2. Read 0x95, slot1 returns 0xDEADBEEF with ready on the first ACCESS cycle → slot_sel=0010, slot_addr=0x05; rdata=0xDEADBEEF, ready=1 two cycles after request, err=0.
3. Read 0x40 (unmapped) → no slot strobe; ready=1, err=1, rdata=0 one cycle after request.
4. Write 0xA0, slot2 never ready, TIMEOUT=16 → slot_write high for exactly 16 cycles; then ready=1, err=1. Second run with slot2 ready exactly on cycle 16 → err=0.
5. read=write=1 at 0x80 → no strobes; ready=1, err=1. Then hold read high in DONE for 5 cycles → ready stays 1 and no second access occurs.
6. Overlapping windows (slot0 0x80/F0, slot1 0x80/C0), read 0x85 → slot_sel=0001. Assert rst during ACCESS → all outputs 0 without waiting for a clk edge; next request completes normally.
